// File: rtl/wgt_ctrl_pkg.sv
// Shared definitions for the weight-load controller: FSM encoding and default geometry.
package wgt_ctrl_pkg;

  localparam int unsigned K_DEF      = 5;
  localparam int unsigned ADDR_W_DEF = 12;
  localparam int unsigned NK_W_DEF   = 8;
  localparam int unsigned KK         = K_DEF * K_DEF;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StFetch   = 3'd1,
    StDrain   = 3'd2,
    StWaitAck = 3'd3,
    StFin     = 3'd4
  } wgt_state_e;

endpackage

// File: rtl/wgt_addr_gen.sv
// Kernel/row/tap counters and SRAM address arithmetic for the weight loader.
module wgt_addr_gen
  import wgt_ctrl_pkg::*;
#(
  parameter int unsigned K      = K_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned NK_W   = NK_W_DEF,
  localparam int unsigned CntW  = (K > 1) ? $clog2(K) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              advance,
  input  logic              kernel_inc,
  input  logic [ADDR_W-1:0] base_addr,
  output logic [ADDR_W-1:0] addr,
  output logic [CntW-1:0]   row,
  output logic [NK_W-1:0]   kernel_idx,
  output logic              last_tap
);

  localparam int unsigned NumTaps = K * K;

  logic [NK_W-1:0] k_q, k_d;
  logic [CntW-1:0] r_q, r_d;
  logic [CntW-1:0] j_q, j_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_q <= '0;
      r_q <= '0;
      j_q <= '0;
    end else begin
      k_q <= k_d;
      r_q <= r_d;
      j_q <= j_d;
    end
  end

  always_comb begin
    k_d = k_q;
    r_d = r_q;
    j_d = j_q;
    if (clear) begin
      k_d = '0;
      r_d = '0;
      j_d = '0;
    end else begin
      if (advance) begin
        if (j_q == CntW'(K - 1)) begin
          j_d = '0;
          r_d = (r_q == CntW'(K - 1)) ? '0 : r_q + CntW'(1);
        end else begin
          j_d = j_q + CntW'(1);
        end
      end
      if (kernel_inc) begin
        k_d = k_q + NK_W'(1);
      end
    end
  end

  // Tap j reads column K-1-j so the rightmost weight enters the shift buffer first.
  always_comb begin
    addr = base_addr
         + ADDR_W'(k_q) * ADDR_W'(NumTaps)
         + ADDR_W'(r_q) * ADDR_W'(K)
         + (ADDR_W'(K - 1) - ADDR_W'(j_q));
  end

  assign row        = r_q;
  assign kernel_idx = k_q;
  assign last_tap   = (r_q == CntW'(K - 1)) && (j_q == CntW'(K - 1));

endmodule

// File: rtl/wgt_load_ctrl.sv
// Weight-load sequencer: fetches KxK kernels from SRAM into K row shift buffers and
// holds each kernel until compute acknowledges it.
module wgt_load_ctrl
  import wgt_ctrl_pkg::*;
#(
  parameter int unsigned K      = K_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned NK_W   = NK_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic [NK_W-1:0]         num_kernels,
  input  logic                    stall,
  input  logic                    kernel_ack,
  output logic                    mem_en,
  output logic [ADDR_W-1:0]       mem_addr,
  input  logic signed [7:0]       mem_rdata,
  output logic signed [7:0]       wgt_input,
  output logic [K-1:0]            wgt_read_row,
  output logic                    kernel_ready,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned CntW = (K > 1) ? $clog2(K) : 1;

  wgt_state_e state_q, state_d;

  logic [ADDR_W-1:0] base_q;
  logic [NK_W-1:0]   nk_q;
  logic              kernel_ready_q, kernel_ready_d;
  logic              rd_valid_q;
  logic [CntW-1:0]   rd_row_q;

  logic              accept;
  logic              clear;
  logic              advance;
  logic              kernel_inc;
  logic              more_kernels;
  logic [ADDR_W-1:0] gen_addr;
  logic [CntW-1:0]   gen_row;
  logic [NK_W-1:0]   gen_kernel;
  logic              gen_last;

  wgt_addr_gen #(
    .K      (K),
    .ADDR_W (ADDR_W),
    .NK_W   (NK_W)
  ) u_addr_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .advance    (advance),
    .kernel_inc (kernel_inc),
    .base_addr  (base_q),
    .addr       (gen_addr),
    .row        (gen_row),
    .kernel_idx (gen_kernel),
    .last_tap   (gen_last)
  );

  assign more_kernels = ({1'b0, gen_kernel} + (NK_W + 1)'(1)) < {1'b0, nk_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      base_q         <= '0;
      nk_q           <= '0;
      kernel_ready_q <= 1'b0;
      rd_valid_q     <= 1'b0;
      rd_row_q       <= '0;
    end else begin
      state_q        <= state_d;
      kernel_ready_q <= kernel_ready_d;
      rd_valid_q     <= mem_en;
      if (mem_en) begin
        rd_row_q <= gen_row;
      end
      if (accept) begin
        base_q <= base_addr;
        nk_q   <= num_kernels;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    kernel_ready_d = kernel_ready_q;
    accept         = 1'b0;
    clear          = 1'b0;
    advance        = 1'b0;
    kernel_inc     = 1'b0;
    mem_en         = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          accept  = 1'b1;
          clear   = 1'b1;
          state_d = (num_kernels != '0) ? StFetch : StFin;
        end
      end
      StFetch: begin
        if (!stall) begin
          mem_en  = 1'b1;
          advance = 1'b1;
          if (gen_last) begin
            state_d = StDrain;
          end
        end
      end
      StDrain: begin
        kernel_ready_d = 1'b1;
        state_d        = StWaitAck;
      end
      StWaitAck: begin
        if (kernel_ack) begin
          kernel_ready_d = 1'b0;
          kernel_inc     = 1'b1;
          state_d        = more_kernels ? StFetch : StFin;
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Address is forced to zero when idle so the bus is quiet between reads.
  assign mem_addr     = mem_en ? gen_addr : '0;
  assign wgt_input    = mem_rdata;
  assign wgt_read_row = rd_valid_q ? (K'(1) << rd_row_q) : '0;
  assign kernel_ready = kernel_ready_q;
  assign busy         = (state_q != StIdle);
  assign done         = (state_q == StFin);

endmodule

// File: tb/tb_wgt_load_ctrl.sv
// Scoreboard bench for wgt_load_ctrl: a job-level model queues expected reads, strobes,
// kernel contents and done pulses; a negedge monitor pops and compares.
module tb_wgt_load_ctrl;
  import wgt_ctrl_pkg::*;

  localparam int unsigned K      = K_DEF;
  localparam int unsigned ADDR_W = ADDR_W_DEF;
  localparam int unsigned NK_W   = NK_W_DEF;
  localparam int unsigned NT     = KK;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    start = 1'b0;
  logic [ADDR_W-1:0]       base_addr = '0;
  logic [NK_W-1:0]         num_kernels = '0;
  logic                    stall = 1'b0;
  logic                    kernel_ack = 1'b0;
  logic                    mem_en;
  logic [ADDR_W-1:0]       mem_addr;
  logic signed [7:0]       mem_rdata = '0;
  logic signed [7:0]       wgt_input;
  logic [K-1:0]            wgt_read_row;
  logic                    kernel_ready;
  logic                    busy;
  logic                    done;

  logic [7:0] sram [4096];
  logic [7:0] rbuf [K][K];

  logic [ADDR_W-1:0] exp_addr_q[$];
  logic [7:0]        exp_data_q[$];
  int                exp_row_q[$];
  logic [7:0]        exp_kern_q[$];
  int                exp_done = 0;

  int n_checks = 0;
  int n_pass   = 0;

  wgt_load_ctrl #(
    .K      (K),
    .ADDR_W (ADDR_W),
    .NK_W   (NK_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .base_addr    (base_addr),
    .num_kernels  (num_kernels),
    .stall        (stall),
    .kernel_ack   (kernel_ack),
    .mem_en       (mem_en),
    .mem_addr     (mem_addr),
    .mem_rdata    (mem_rdata),
    .wgt_input    (wgt_input),
    .wgt_read_row (wgt_read_row),
    .kernel_ready (kernel_ready),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  // Synchronous-read SRAM model.
  always @(posedge clk) begin
    if (mem_en) mem_rdata <= sram[mem_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Job-level reference: kernels in order, rows in order, columns right to left.
  task automatic model_job(input logic [ADDR_W-1:0] base, input logic [NK_W-1:0] nk);
    for (int kk = 0; kk < int'(nk); kk++) begin
      for (int r = 0; r < int'(K); r++) begin
        for (int col = int'(K) - 1; col >= 0; col--) begin
          logic [ADDR_W-1:0] a;
          a = base + ADDR_W'(kk * int'(NT) + r * int'(K) + col);
          exp_addr_q.push_back(a);
          exp_data_q.push_back(sram[a]);
          exp_row_q.push_back(r);
        end
      end
      for (int r = 0; r < int'(K); r++) begin
        for (int c = 0; c < int'(K); c++) begin
          logic [ADDR_W-1:0] a;
          a = base + ADDR_W'(kk * int'(NT) + r * int'(K) + c);
          exp_kern_q.push_back(sram[a]);
        end
      end
    end
    exp_done++;
  endtask

  task automatic flush_model();
    exp_addr_q.delete();
    exp_data_q.delete();
    exp_row_q.delete();
    exp_kern_q.delete();
    exp_done = 0;
  endtask

  // Monitor: compares every DUT event against the head of the matching queue.
  initial begin
    logic kr_prev;
    logic done_prev;
    kr_prev   = 1'b0;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        kr_prev   = 1'b0;
        done_prev = 1'b0;
      end else begin
        if (mem_en) begin
          if (exp_addr_q.size() == 0) check("unexpected_read", {31'b0, mem_en}, 32'd0);
          else check("mem_addr", {20'b0, mem_addr}, {20'b0, exp_addr_q.pop_front()});
        end
        if (wgt_read_row != '0) begin
          if (exp_row_q.size() == 0) begin
            check("unexpected_strobe", {27'b0, wgt_read_row}, 32'd0);
          end else begin
            int row;
            logic [7:0] d;
            row = exp_row_q.pop_front();
            d   = exp_data_q.pop_front();
            check("strobe_row", {27'b0, wgt_read_row}, 32'd1 << row);
            check("wgt_input", {24'b0, wgt_input}, {24'b0, d});
            for (int c = int'(K) - 1; c > 0; c--) rbuf[row][c] = rbuf[row][c-1];
            rbuf[row][0] = wgt_input;
          end
        end
        if (kernel_ready) check("no_strobe_in_wait", {27'b0, wgt_read_row}, 32'd0);
        if (kernel_ready && !kr_prev) begin
          if (exp_kern_q.size() < int'(NT)) begin
            check("unexpected_kernel_ready", {31'b0, kernel_ready}, 32'd0);
          end else begin
            for (int r = 0; r < int'(K); r++)
              for (int c = 0; c < int'(K); c++)
                check($sformatf("buf_r%0d_c%0d", r, c), {24'b0, rbuf[r][c]},
                      {24'b0, exp_kern_q.pop_front()});
          end
        end
        if (done) begin
          check("done_expected", exp_done, (exp_done > 0) ? exp_done : 1);
          check("busy_in_fin", {31'b0, busy}, 32'd1);
          if (exp_done > 0) exp_done--;
        end
        if (done_prev) check("busy_after_done", {31'b0, busy}, 32'd0);
        kr_prev   = kernel_ready;
        done_prev = done;
      end
    end
  end

  task automatic run_job(input logic [ADDR_W-1:0] base, input logic [NK_W-1:0] nk,
                         input int ack_dly, input bit rnd, input int stall_at,
                         input int stall_len, input int exp_kr, input int mid_start_at);
    int cyc;
    int kr_cnt;
    bit seen_kr;
    model_job(base, nk);
    @(posedge clk); #1;
    start = 1'b1; base_addr = base; num_kernels = nk; stall = 1'b0; kernel_ack = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; base_addr = ADDR_W'($urandom); num_kernels = NK_W'($urandom);
    cyc = 1; kr_cnt = 0; seen_kr = 1'b0;
    check("busy_after_start", {31'b0, busy}, 32'd1);
    if (nk == '0) begin
      check("done_after_start_nk0", {31'b0, done}, 32'd1);
      check("no_read_nk0", {31'b0, mem_en}, 32'd0);
    end
    while (busy && cyc < 4000) begin
      stall = rnd ? ($urandom_range(0, 3) == 0) : (cyc >= stall_at && cyc < stall_at + stall_len);
      start = (cyc == mid_start_at);
      if (start) begin
        base_addr   = ~base;
        num_kernels = nk + NK_W'(1);
      end
      kernel_ack = 1'b0;
      if (kernel_ready) begin
        if (!seen_kr) begin
          seen_kr = 1'b1;
          if (exp_kr > 0) check("kernel_ready_latency", cyc, exp_kr);
        end
        if (kr_cnt == ack_dly) begin
          kernel_ack = 1'b1;
          kr_cnt = 0;
        end else begin
          kr_cnt++;
        end
      end else if (rnd) begin
        kernel_ack = ($urandom_range(0, 7) == 0);
      end
      #1;
      if (stall && !rnd) check("mem_en_stalled", {31'b0, mem_en}, 32'd0);
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0; stall = 1'b0; kernel_ack = 1'b0;
    check("job_finished", {31'b0, busy}, 32'd0);
    check("reads_all_issued", exp_addr_q.size(), 32'd0);
    check("strobes_all_seen", exp_row_q.size(), 32'd0);
    check("done_seen", exp_done, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_en"}, {31'b0, mem_en}, 32'd0);
    check({tag, "_mem_addr"}, {20'b0, mem_addr}, 32'd0);
    check({tag, "_read_row"}, {27'b0, wgt_read_row}, 32'd0);
    check({tag, "_kernel_ready"}, {31'b0, kernel_ready}, 32'd0);
    check({tag, "_busy"}, {31'b0, busy}, 32'd0);
    check({tag, "_done"}, {31'b0, done}, 32'd0);
  endtask

  task automatic reset_mid_fetch(input logic [ADDR_W-1:0] base);
    model_job(base, NK_W'(2));
    @(posedge clk); #1;
    start = 1'b1; base_addr = base; num_kernels = NK_W'(2);
    @(posedge clk); #1;
    start = 1'b0;
    for (int cyc = 1; cyc < 12; cyc++) begin
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rst_mid");
    flush_model();
    @(posedge clk); #1;
    check("rst_no_strobe", {27'b0, wgt_read_row}, 32'd0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_released_idle", {31'b0, busy}, 32'd0);
    check("rst_released_no_strobe", {27'b0, wgt_read_row}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 4096; i++) sram[i] = 8'(i);
    for (int r = 0; r < int'(K); r++)
      for (int c = 0; c < int'(K); c++) rbuf[r][c] = '0;
    #1 check_reset_outputs("reset");
    #22 rst_n = 1'b1;

    run_job(12'h100, 8'd1, 2, 1'b0, 1000, 0, 27, -1);
    check("buf_row2_tap3", {24'b0, rbuf[2][3]}, 32'h0D);
    run_job(12'h100, 8'd3, 4, 1'b0, 1000, 0, 27, -1);
    run_job(12'h040, 8'd1, 1, 1'b0, 8, 3, 30, -1);
    run_job(12'h200, 8'd0, 0, 1'b0, 1000, 0, 0, -1);
    run_job(12'hFF0, 8'd2, 0, 1'b0, 1000, 0, 27, -1);
    run_job(12'h300, 8'd1, 3, 1'b0, 1000, 0, 27, 5);
    reset_mid_fetch(12'h123);
    run_job(12'h123, 8'd1, 0, 1'b0, 1000, 0, 27, -1);

    for (int i = 0; i < 4096; i++) sram[i] = 8'($urandom);
    for (int n = 0; n < 8; n++) begin
      run_job(ADDR_W'($urandom), NK_W'($urandom_range(0, 3)), int'($urandom_range(0, 6)),
              1'b1, 0, 0, 0, int'($urandom_range(2, 40)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
